// File: rtl/fsm_seq_monitor.sv
// Passive checker for the 6-state step sequencer (000,001,011,101,111,010).
// Decodes position, counts laps and latches a sticky error on illegal codes/transitions.
module fsm_seq_monitor #(
    parameter int unsigned LAP_W      = 8,
    parameter int unsigned CHECK_STEP = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       q_in,
    input  logic             step_in,
    input  logic             err_clr,
    output logic             valid,
    output logic [2:0]       pos,
    output logic [LAP_W-1:0] lap_count,
    output logic             lap_pulse,
    output logic             err,
    output logic [5:0]       err_pair
);

    localparam bit STEP_CHK = (CHECK_STEP != 0);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_TRACK = 2'd1,
        S_ERROR = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       prev_q_q, prev_q_d;
    logic             step_dly_q, step_dly_d;
    logic             valid_q, valid_d;
    logic [2:0]       pos_q, pos_d;
    logic [LAP_W-1:0] lap_count_q, lap_count_d;
    logic             lap_pulse_q, lap_pulse_d;
    logic             err_q, err_d;
    logic [5:0]       err_pair_q, err_pair_d;

    logic             hold_ok;
    logic             adv_ok;

    function automatic logic [2:0] next_code(input logic [2:0] c);
        case (c)
            3'b000:  return 3'b001;
            3'b001:  return 3'b011;
            3'b011:  return 3'b101;
            3'b101:  return 3'b111;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic is_legal(input logic [2:0] c);
        return !((c == 3'b100) || (c == 3'b110));
    endfunction

    function automatic logic [2:0] to_index(input logic [2:0] c);
        case (c)
            3'b001:  return 3'd1;
            3'b011:  return 3'd2;
            3'b101:  return 3'd3;
            3'b111:  return 3'd4;
            3'b010:  return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    // A hold needs step low and an advance needs step high, one edge earlier.
    assign hold_ok = (q_in == prev_q_q) && (!STEP_CHK || !step_dly_q);
    assign adv_ok  = (q_in == next_code(prev_q_q)) && (!STEP_CHK || step_dly_q);

    // Next-state and output computation
    always_comb begin
        state_d     = state_q;
        prev_q_d    = prev_q_q;
        step_dly_d  = step_in;
        valid_d     = valid_q;
        pos_d       = pos_q;
        lap_count_d = lap_count_q;
        lap_pulse_d = 1'b0;
        err_d       = err_q;
        err_pair_d  = err_pair_q;

        case (state_q)
            S_INIT: begin
                if (is_legal(q_in)) begin
                    state_d  = S_TRACK;
                    prev_q_d = q_in;
                    pos_d    = to_index(q_in);
                    valid_d  = 1'b1;
                end else begin
                    state_d    = S_ERROR;
                    err_d      = 1'b1;
                    err_pair_d = {3'b000, q_in};
                end
            end
            S_TRACK: begin
                if (adv_ok) begin
                    prev_q_d = q_in;
                    pos_d    = to_index(q_in);
                    if (prev_q_q == 3'b010) begin
                        lap_count_d = lap_count_q + LAP_W'(1);
                        lap_pulse_d = 1'b1;
                    end
                end else if (!hold_ok) begin
                    state_d    = S_ERROR;
                    err_d      = 1'b1;
                    valid_d    = 1'b0;
                    err_pair_d = {prev_q_q, q_in};
                end
            end
            S_ERROR: begin
                if (err_clr) begin
                    state_d = S_INIT;
                    err_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_INIT;
            prev_q_q    <= 3'b000;
            step_dly_q  <= 1'b0;
            valid_q     <= 1'b0;
            pos_q       <= 3'd0;
            lap_count_q <= '0;
            lap_pulse_q <= 1'b0;
            err_q       <= 1'b0;
            err_pair_q  <= 6'd0;
        end else begin
            state_q     <= state_d;
            prev_q_q    <= prev_q_d;
            step_dly_q  <= step_dly_d;
            valid_q     <= valid_d;
            pos_q       <= pos_d;
            lap_count_q <= lap_count_d;
            lap_pulse_q <= lap_pulse_d;
            err_q       <= err_d;
            err_pair_q  <= err_pair_d;
        end
    end

    assign valid     = valid_q;
    assign pos       = pos_q;
    assign lap_count = lap_count_q;
    assign lap_pulse = lap_pulse_q;
    assign err       = err_q;
    assign err_pair  = err_pair_q;

endmodule

// File: tb/tb_fsm_seq_monitor.sv
// Bench for fsm_seq_monitor: two configurations share one stimulus stream and
// are compared every cycle against a sequence-level reference model.
module tb_fsm_seq_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] q_in;
    logic       step_in;
    logic       err_clr;

    logic       valid_a, lap_pulse_a, err_a;
    logic [2:0] pos_a;
    logic [7:0] lap_count_a;
    logic [5:0] err_pair_a;

    logic       valid_b, lap_pulse_b, err_b;
    logic [2:0] pos_b;
    logic [1:0] lap_count_b;
    logic [5:0] err_pair_b;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fsm_seq_monitor #(.LAP_W(8), .CHECK_STEP(1)) u_dut_a (
        .clk(clk), .reset(reset), .q_in(q_in), .step_in(step_in), .err_clr(err_clr),
        .valid(valid_a), .pos(pos_a), .lap_count(lap_count_a), .lap_pulse(lap_pulse_a),
        .err(err_a), .err_pair(err_pair_a)
    );

    fsm_seq_monitor #(.LAP_W(2), .CHECK_STEP(0)) u_dut_b (
        .clk(clk), .reset(reset), .q_in(q_in), .step_in(step_in), .err_clr(err_clr),
        .valid(valid_b), .pos(pos_b), .lap_count(lap_count_b), .lap_pulse(lap_pulse_b),
        .err(err_b), .err_pair(err_pair_b)
    );

    // Reference model: the legal cycle as a lookup table; index 0 is config A, 1 is config B.
    int seq_code [6] = '{0, 1, 3, 5, 7, 2};
    int cfg_cs   [2] = '{1, 0};
    int cfg_w    [2] = '{8, 2};
    int m_mode   [2];   // 0 acquiring, 1 tracking, 2 errored
    int m_valid  [2];
    int m_pos    [2];
    int m_lap    [2];
    int m_pulse  [2];
    int m_err    [2];
    int m_pair   [2];
    int m_prevq  [2];
    int m_stepd;

    function automatic int code_index(input int c);
        for (int i = 0; i < 6; i++)
            if (seq_code[i] == c) return i;
        return -1;
    endfunction

    task automatic model_edge();
        int qi;
        int p;
        qi = int'(q_in);
        for (int k = 0; k < 2; k++) begin
            m_pulse[k] = 0;
            if (reset) begin
                m_mode[k] = 0; m_valid[k] = 0; m_pos[k] = 0; m_lap[k] = 0;
                m_err[k] = 0; m_pair[k] = 0; m_prevq[k] = 0;
            end else if (m_mode[k] == 2) begin
                if (err_clr) begin
                    m_mode[k] = 0;
                    m_err[k]  = 0;
                end
            end else if (m_mode[k] == 0) begin
                if (code_index(qi) >= 0) begin
                    m_mode[k] = 1; m_prevq[k] = qi; m_pos[k] = code_index(qi); m_valid[k] = 1;
                end else begin
                    m_mode[k] = 2; m_err[k] = 1; m_pair[k] = qi;
                end
            end else begin
                p = code_index(m_prevq[k]);
                if (qi == m_prevq[k] && (cfg_cs[k] == 0 || m_stepd == 0)) begin
                    // legal hold
                end else if (qi == seq_code[(p + 1) % 6] && (cfg_cs[k] == 0 || m_stepd == 1)) begin
                    m_prevq[k] = qi;
                    m_pos[k]   = (p + 1) % 6;
                    if (p == 5) begin
                        m_lap[k]   = (m_lap[k] + 1) % (1 << cfg_w[k]);
                        m_pulse[k] = 1;
                    end
                end else begin
                    m_mode[k] = 2; m_err[k] = 1; m_valid[k] = 0;
                    m_pair[k] = m_prevq[k] * 8 + qi;
                end
            end
        end
        m_stepd = reset ? 0 : int'(step_in);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check("a_valid",     8'(valid_a),     8'(m_valid[0]));
        check("a_pos",       8'(pos_a),       8'(m_pos[0]));
        check("a_lap_count", 8'(lap_count_a), 8'(m_lap[0]));
        check("a_lap_pulse", 8'(lap_pulse_a), 8'(m_pulse[0]));
        check("a_err",       8'(err_a),       8'(m_err[0]));
        check("a_err_pair",  8'(err_pair_a),  8'(m_pair[0]));
        check("b_valid",     8'(valid_b),     8'(m_valid[1]));
        check("b_pos",       8'(pos_b),       8'(m_pos[1]));
        check("b_lap_count", 8'(lap_count_b), 8'(m_lap[1]));
        check("b_lap_pulse", 8'(lap_pulse_b), 8'(m_pulse[1]));
        check("b_err",       8'(err_b),       8'(m_err[1]));
        check("b_err_pair",  8'(err_pair_b),  8'(m_pair[1]));
    endtask

    task automatic drive(input logic rs, input logic [2:0] q, input logic st, input logic clr);
        reset   = rs;
        q_in    = q;
        step_in = st;
        err_clr = clr;
        cyc();
    endtask

    // Walks n codes forward from cur; step is high on every presented code but the last.
    task automatic walk(inout int cur, input int n);
        for (int i = 0; i < n; i++) begin
            cur = (cur + 1) % 6;
            drive(1'b0, 3'(seq_code[cur]), (i != n - 1), 1'b0);
        end
    endtask

    initial begin
        int cur;
        int r;
        logic [2:0] last_q;
        logic [2:0] nq;
        reset = 1'b1; q_in = 3'b000; step_in = 1'b0; err_clr = 1'b0;
        m_stepd = 0;
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_valid[k] = 0; m_pos[k] = 0; m_lap[k] = 0;
            m_pulse[k] = 0; m_err[k] = 0; m_pair[k] = 0; m_prevq[k] = 0;
        end

        // Reset, then one full lap
        drive(1'b1, 3'b000, 1'b0, 1'b0);
        drive(1'b1, 3'b000, 1'b0, 1'b0);
        drive(1'b0, 3'b000, 1'b1, 1'b0);
        cur = 0;
        walk(cur, 6);
        check("lap1_count", lap_count_a, 8'd1);
        drive(1'b0, 3'b000, 1'b0, 1'b0);
        check("lap1_no_err", 8'(err_a), 8'd0);

        // Four more laps; 2-bit counter wraps
        drive(1'b0, 3'b000, 1'b1, 1'b0);
        walk(cur, 24);
        check("wrap_b", 8'(lap_count_b), 8'd1);

        // Multi-step jump 011 -> 111, then frozen outputs
        drive(1'b1, 3'b000, 1'b0, 1'b0);
        drive(1'b0, 3'b000, 1'b1, 1'b0);
        cur = 0;
        walk(cur, 2);
        drive(1'b0, 3'b111, 1'b1, 1'b0);
        check("jump_pair", 8'(err_pair_a), 8'h1F);
        check("jump_pos",  8'(pos_a),      8'd2);
        drive(1'b0, 3'b000, 1'b0, 1'b0);

        // Advance without step: error with step checking, accepted without
        drive(1'b1, 3'b000, 1'b0, 1'b0);
        drive(1'b0, 3'b001, 1'b0, 1'b0);
        drive(1'b0, 3'b011, 1'b0, 1'b0);
        check("nostep_pair_a", 8'(err_pair_a), 8'h0B);
        check("nostep_pos_b",  8'(pos_b),      8'd2);

        // Illegal code after reset, then recovery through err_clr
        drive(1'b1, 3'b000, 1'b0, 1'b0);
        drive(1'b0, 3'b110, 1'b0, 1'b0);
        check("illegal_pair", 8'(err_pair_a), 8'h06);
        drive(1'b0, 3'b101, 1'b0, 1'b1);
        drive(1'b0, 3'b101, 1'b0, 1'b0);
        check("recover_pos", 8'(pos_a), 8'd3);

        // reset and err_clr together while in error
        drive(1'b0, 3'b100, 1'b0, 1'b0);
        drive(1'b1, 3'b100, 1'b0, 1'b1);
        check("rst_clr_pair", 8'(err_pair_a), 8'd0);

        // Randomised traffic, mostly legal advances
        last_q = 3'b000;
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70)
                nq = (code_index(int'(last_q)) < 0) ? 3'b000
                   : 3'(seq_code[(code_index(int'(last_q)) + 1) % 6]);
            else if (r < 85)
                nq = last_q;
            else
                nq = 3'($urandom_range(0, 7));
            drive(($urandom_range(0, 49) == 0), nq, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) == 0));
            last_q = nq;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
